// File: rtl/mult_pkg.sv
// mult_pkg: shared types, widths and carry look-ahead helper for the shift-add multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int OP_W = 16;
  localparam int PROD_W = 32;
  localparam int CNT_W = 4;
  localparam int ITER = 16;
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c);
    return {g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0] | p[3] & p[2] & p[1] & p[0] & c,
            g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c,
            g[1] | p[1] & g[0] | p[1] & p[0] & c,
            g[0] | p[0] & c};
  endfunction
endpackage

// File: rtl/carry_look_ahead_16bit.sv
// carry_look_ahead_16bit: two-level 4x4 carry look-ahead adder
module carry_look_ahead_16bit
  import mult_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic [OP_W-1:0] sum,
  output logic            cout
);
  logic [OP_W-1:0] g, p, c;
  logic [3:0] gg, gp, gc;
  assign g = a & b;
  assign p = a ^ b;
  for (genvar j = 0; j < 4; j++) begin : grp
    logic [3:0] lc;
    assign gg[j] = cla4(g[4*j +: 4], p[4*j +: 4], 1'b0) >> 3 != 4'd0;
    assign gp[j] = &p[4*j +: 4];
    assign lc = cla4(g[4*j +: 4], p[4*j +: 4], j == 0 ? cin : gc[j-1]);
    assign c[4*j +: 4] = {lc[2:0], j == 0 ? cin : gc[j-1]};
  end
  assign gc = cla4(gg, gp, cin);
  assign sum = p ^ c;
  assign cout = gc[3];
endmodule

// File: rtl/shift_add_multiplier_16bit.sv
// shift_add_multiplier_16bit: sequential 16x16 unsigned multiplier, one CLA add-and-shift per clock
module shift_add_multiplier_16bit
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);
  state_t state;
  logic [OP_W-1:0] mcand, acc_hi, q, sum;
  logic [CNT_W-1:0] count;
  logic cout;
  carry_look_ahead_16bit adder (
    .a(acc_hi),
    .b(q[0] ? mcand : '0),
    .cin(1'b0),
    .sum(sum),
    .cout(cout)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      product <= '0;
      mcand <= '0;
      acc_hi <= '0;
      q <= '0;
      count <= '0;
    end else begin
      done <= 1'b0;
      if (state != RUN && start) begin
        mcand <= a;
        acc_hi <= '0;
        q <= b;
        count <= '0;
        busy <= 1'b1;
        state <= RUN;
      end else if (state == RUN) begin
        {acc_hi, q} <= {cout, sum, q[OP_W-1:1]};
        count <= count + 1'b1;
        if (count == CNT_W'(ITER - 1)) begin
          product <= {cout, sum, q[OP_W-1:1]};
          done <= 1'b1;
          busy <= 1'b0;
          state <= DONE;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier_16bit.sv
// tb_shift_add_multiplier_16bit: directed scoreboard bench for the shift-add multiplier
module tb_shift_add_multiplier_16bit;
  logic clk = 1'b0;
  logic rst, start;
  logic [15:0] a, b;
  logic busy, done;
  logic [31:0] product;
  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];
  logic [31:0] last = '0;
  always #5 clk = ~clk;
  shift_add_multiplier_16bit dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .product(product)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    sb.push_back(32'(x) * 32'(y));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("product_hold", product, last);
  endtask
  task automatic finish_run(input string tag, input int poke, input logic nb);
    int n = 1;
    logic [31:0] e = 'x;
    do begin
      @(negedge clk);
      n++;
      if (n == poke) begin
        start = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
      end else if (n == poke + 1) begin
        start = 1'b0;
      end
    end while (done !== 1'b1 && n < 40);
    chk({tag, "_latency"}, 32'(n), 32'd17);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (sb.size() > 0) e = sb.pop_front();
    chk({tag, "_product"}, product, e);
    last = e;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'(nb));
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", product, 32'd0);
    rst = 1'b0;
    go(16'h0003, 16'h0005);
    finish_run("small", 0, 1'b0);
    go(16'hFFFF, 16'hFFFF);
    finish_run("max", 0, 1'b0);
    go(16'h1234, 16'h0000);
    finish_run("zero_b", 0, 1'b0);
    go(16'h0000, 16'hABCD);
    finish_run("zero_a", 0, 1'b0);
    go(16'h00FF, 16'h0101);
    finish_run("ignored_start", 5, 1'b0);
    go(16'h8000, 16'h8000);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    a = 16'h0001;
    b = 16'h0001;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_done", 32'(done), 32'd0);
    chk("midrun_reset_product", product, 32'd0);
    void'(sb.pop_back());
    last = '0;
    go(16'h0002, 16'h0007);
    finish_run("after_reset", 0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a = 16'h0010;
    b = 16'h0010;
    sb.push_back(32'h0000_0100);
    @(negedge clk);
    a = 16'h0100;
    b = 16'h0100;
    sb.push_back(32'h0001_0000);
    finish_run("b2b_first", 0, 1'b1);
    start = 1'b0;
    finish_run("b2b_second", 0, 1'b0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
